spart_tx: RTL and testbench

- SPART transmit datapath. Consumes the oversampled baud enable from the baud rate generator and serialises bytes on txd as 8N1 frames, LSB first.
- Double-buffered: a one-byte holding register is written from the bus side, and a shift register drives the line.
- Sits beside the receiver and shares the same baud enable.
- tbr (transmit buffer ready) is the bus-side status bit.

---
 rtl/spart_tx.sv | 123 ++++++++++++
 tb/tb_spart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_tx.sv
// SPART transmitter: double-buffered 8N1 serialiser, LSB first, bit timing
// derived from the oversampled baud enable shared with the receiver.
module spart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              brg_ready,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tbr,
  output logic              tx_busy,
  output logic              tx_overrun,
  output logic              txd,
  output logic [1:0]        dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_tick;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic              r_tbr;
  logic              r_txd;
  logic              r_ovr;
  logic              w_bit_end;
  logic              w_last_bit;
  logic              w_launch;

  // Load handshake: tx_load is a one-cycle valid, tbr is ready. A load with
  // tbr=1 is taken; a load with tbr=0 is dropped and flagged by tx_overrun.
  assign w_bit_end  = sample_en && (r_state != IDLE) && (r_tick == TICK_MAX);
  assign w_last_bit = (r_bit == BIT_MAX);
  assign w_launch   = sample_en && !r_tbr && brg_ready &&
                      ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && w_last_bit) w_state_nxt = STOP;
      STOP: begin
        if (w_launch)       w_state_nxt = START;
        else if (w_bit_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_hold  <= '0;
      r_shift <= '0;
      r_tbr   <= 1'b1;
      r_txd   <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= tx_load && !r_tbr;
      // Launch needs tbr=0 and an accepted load needs tbr=1, so they never collide.
      if (tx_load && r_tbr) begin
        r_hold <= tx_data;
        r_tbr  <= 1'b0;
      end
      if (w_launch) begin
        r_shift <= r_hold;
        r_txd   <= 1'b0;
        r_tbr   <= 1'b1;
        r_tick  <= '0;
      end else begin
        if (sample_en && (r_state != IDLE)) r_tick <= r_tick + TW'(1);
        if (w_bit_end) begin
          case (r_state)
            START: begin
              r_txd <= r_shift[0];
              r_bit <= '0;
            end
            DATA: begin
              if (w_last_bit) begin
                r_txd <= 1'b1;
              end else begin
                r_shift <= r_shift >> 1;
                r_txd   <= r_shift[1];
                r_bit   <= r_bit + BW'(1);
              end
            end
            STOP:    r_txd <= 1'b1;
            default: r_txd <= 1'b1;
          endcase
        end
      end
    end
  end

  assign tbr        = r_tbr;
  assign tx_busy    = (r_state != IDLE);
  assign tx_overrun = r_ovr;
  assign txd        = r_txd;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: frame-level reference model, line decoder with expected
// byte queue, table of known frames and directed multi-cycle corner cases.
module tb_spart_tx;

  localparam int OS          = 16;
  localparam int FRAME_TICKS = 10 * OS;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic       brg_ready;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       tbr;
  logic       tx_busy;
  logic       tx_overrun;
  logic       txd;
  logic [1:0] dbg_state;

  spart_tx #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .brg_ready  (brg_ready),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .tbr        (tbr),
    .tx_busy    (tx_busy),
    .tx_overrun (tx_overrun),
    .txd        (txd),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle count / baud enable ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int se_div  = 4;
  bit se_on   = 1'b1;
  int se_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    sample_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (se_on && se_cnt >= se_div - 1) begin
        sample_en = 1'b1;
        se_cnt    = 0;
      end else begin
        sample_en = 1'b0;
        if (se_on) se_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: frame = 10*OS enable pulses ----------------
  int         m_left  = 0;
  bit         m_full  = 1'b0;
  bit         m_ovr   = 1'b0;
  logic [7:0] m_byte  = 8'h00;
  logic [9:0] m_frame = 10'h3ff;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left  <= 0;
      m_full  <= 1'b0;
      m_ovr   <= 1'b0;
      m_byte  <= 8'h00;
      m_frame <= 10'h3ff;
      exp_q.delete();
    end else begin
      m_ovr <= tx_load && m_full;
      if (tx_load && !m_full) begin
        m_full <= 1'b1;
        m_byte <= tx_data;
        exp_q.push_back(tx_data);
      end
      if (sample_en) begin
        if (m_full && brg_ready && m_left <= 1) begin
          m_left  <= FRAME_TICKS;
          m_frame <= {1'b1, m_byte, 1'b0};
          m_full  <= 1'b0;
        end else if (m_left > 0) begin
          m_left <= m_left - 1;
        end
      end
    end
  end

  function automatic logic exp_txd();
    if (m_left == 0) return 1'b1;
    return m_frame[(FRAME_TICKS - m_left) / OS];
  endfunction

  always @(negedge clk) begin
    check("txd", txd, exp_txd());
    check("tbr", tbr, !m_full);
    check("tx_busy", tx_busy, m_left != 0);
    check("tx_overrun", tx_overrun, m_ovr);
  end

  // ---------------- line decoder / scoreboard ----------------
  bit         d_act  = 1'b0;
  int         d_pcnt = 0;
  logic [7:0] d_byte = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_act  <= 1'b0;
      d_pcnt <= 0;
    end else if (sample_en) begin
      if (!d_act) begin
        if (txd == 1'b0) begin
          d_act  <= 1'b1;
          d_pcnt <= 1;
        end
      end else begin
        d_pcnt <= d_pcnt + 1;
        if (d_pcnt % OS == OS / 2) begin
          if (d_pcnt / OS == 0) begin
            check("start_bit", txd, 1'b0);
          end else if (d_pcnt / OS <= 8) begin
            d_byte[d_pcnt / OS - 1] <= txd;
          end else begin
            check("stop_bit", txd, 1'b1);
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL rx_byte: got frame %0h, expected no frame", d_byte);
            end else begin
              check("rx_byte", d_byte, exp_q.pop_front());
            end
            d_act <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [7:0] d);
    @(posedge clk); #1;
    tx_load = 1'b1;
    tx_data = d;
    @(posedge clk); #1;
    tx_load = 1'b0;
  endtask

  task automatic set_brg(input logic v);
    @(posedge clk); #1;
    brg_ready = v;
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy !== val) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: tx_busy=%b after %0d cycles, expected %b", name, tx_busy, n, val);
    end
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line order: bit 0 is the start bit
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         l_cyc;
    int         n;
    logic [9:0] f;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'h81, 10'b1100000010};

    rst       = 1'b1;
    brg_ready = 1'b1;
    tx_load   = 1'b0;
    tx_data   = 8'h00;
    #2 rst = 1'b0;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_tbr", tbr, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_overrun", tx_overrun, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // idle with the baud enable running
    repeat (200) begin
      @(negedge clk);
      check("idle_txd", txd, 1'b1);
      check("idle_tbr", tbr, 1'b1);
      check("idle_busy", tx_busy, 1'b0);
    end

    // table of known frames, sampled mid-bit, 64 clocks per bit
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].data);
      wait_busy(1'b1, 100, "tbl_launch");
      l_cyc = cyc;
      check("tbl_launch_tbr", tbr, 1'b1);
      f = vecs[i].frame;
      for (int k = 0; k < 10; k++) begin
        wait_until_cyc(l_cyc + 64 * k + 32);
        check("tbl_frame_bit", txd, f[k]);
      end
      wait_busy(1'b0, 700, "tbl_done");
      check("tbl_frame_len", cyc - l_cyc, 640);
    end

    // back-to-back frames and a dropped third byte
    do_load(8'h3C);
    wait_busy(1'b1, 100, "b2b_launch");
    l_cyc = cyc;
    do_load(8'hC3);
    do_load(8'hD7);
    @(negedge clk);
    check("overrun_pulse", tx_overrun, 1'b1);
    @(negedge clk);
    check("overrun_clear", tx_overrun, 1'b0);
    wait_busy(1'b0, 1400, "b2b_done");
    check("b2b_len", cyc - l_cyc, 1280);

    // brg_ready gating and mid-frame drop
    set_brg(1'b0);
    do_load(8'h55);
    repeat (100) @(negedge clk);
    check("brg_hold_txd", txd, 1'b1);
    check("brg_hold_tbr", tbr, 1'b0);
    check("brg_hold_busy", tx_busy, 1'b0);
    set_brg(1'b1);
    wait_busy(1'b1, 8, "brg_launch");
    repeat (200) @(negedge clk);
    set_brg(1'b0);
    wait_busy(1'b0, 700, "brg_drop_done");
    check("brg_drop_tbr", tbr, 1'b1);
    set_brg(1'b1);

    // asynchronous reset during data bit 3 of 0xFF
    do_load(8'hFF);
    wait_busy(1'b1, 100, "rst_launch");
    l_cyc = cyc;
    wait_until_cyc(l_cyc + 64 * 4 + 32);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_tbr", tbr, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (300) @(negedge clk);
    check("post_rst_txd", txd, 1'b1);
    check("post_rst_busy", tx_busy, 1'b0);

    // baud enable stalled mid-DATA
    do_load(8'h96);
    wait_busy(1'b1, 100, "frz_launch");
    l_cyc = cyc;
    wait_until_cyc(l_cyc + 64 * 3 + 20);
    se_on = 1'b0;
    repeat (1000) @(negedge clk);
    check("frz_txd", txd, 1'b1);
    check("frz_busy", tx_busy, 1'b1);
    se_on = 1'b1;
    wait_busy(1'b0, 800, "frz_done");

    // randomized loads, enable rates and brg_ready
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      se_div = $urandom_range(1, 4);
      set_brg(1'($urandom_range(0, 4) != 0));
      do_load(8'($urandom_range(0, 255)));
    end
    set_brg(1'b1);
    se_div = 2;
    n = 0;
    @(negedge clk);
    while (!(tbr === 1'b1 && tx_busy === 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!(tbr === 1'b1 && tx_busy === 1'b0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: tbr=%b tx_busy=%b after %0d cycles, expected 1/0", tbr, tx_busy, n);
    end
    repeat (20) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
